// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding
// select codes, the pipeline-control bundle and small match helpers.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic ifid_flush;
    logic idex_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_ADVANCE = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_HOLD    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_FLUSH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  // A stall freezes PC and IF/ID while a bubble is written into ID/EX.
  localparam pipe_ctrl_t CTRL_STALL   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  // Producer rd matches consumer rs; x0 is hardwired zero and never matches.
  function automatic logic reg_match(input logic [4:0] rd, input logic we,
                                     input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

  function automatic logic [1:0] fwd_select(input logic [4:0] rs,
                                            input logic [4:0] mem_rd,
                                            input logic       mem_we,
                                            input logic [4:0] wb_rd,
                                            input logic       wb_we);
    if (reg_match(mem_rd, mem_we, rs)) return FWD_MEM;
    if (reg_match(wb_rd, wb_we, rs))   return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/hold decode, EX operand forwarding
// (macro HAZARD_FWD_EN; without it RAW hazards stall instead) and mem_busy timeout.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  input  logic       ex_branch_taken,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  input  logic       mem_busy,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       idex_write,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mem_timeout
);
  import hazard_pkg::*;

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             lu_stall_q, lu_stall_d;

  logic       load_use;
  logic       lu_fire;
  logic       raw_hit;
  logic       lu_issue;
  pipe_ctrl_t run_ctrl;
  pipe_ctrl_t ctrl;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  // Once a load-use bubble has been inserted the consumer may proceed.
  assign lu_fire  = load_use && !lu_stall_q;

`ifdef HAZARD_FWD_EN
  logic unused_raw_inputs;

  assign raw_hit = 1'b0;
  assign fwd_a   = fwd_select(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  assign fwd_b   = fwd_select(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  assign unused_raw_inputs = ex_reg_write;
`else
  logic unused_fwd_inputs;

  // Without bypass paths every in-flight producer of an ID source must drain.
  assign raw_hit = reg_match(ex_rd,  ex_reg_write,  id_rs1) ||
                   reg_match(ex_rd,  ex_reg_write,  id_rs2) ||
                   reg_match(mem_rd, mem_reg_write, id_rs1) ||
                   reg_match(mem_rd, mem_reg_write, id_rs2);
  assign fwd_a   = FWD_RF;
  assign fwd_b   = FWD_RF;
  assign unused_fwd_inputs = ^{ex_rs1, ex_rs2, wb_rd, wb_reg_write};
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    run_ctrl = CTRL_ADVANCE;
    lu_issue = 1'b0;
    if (ex_branch_taken) begin
      run_ctrl = CTRL_FLUSH;
    end else if (lu_fire || raw_hit) begin
      run_ctrl = CTRL_STALL;
      lu_issue = lu_fire;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    lu_stall_d = 1'b0;
    ctrl       = CTRL_HOLD;
    unique case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          state_d    = ST_WAIT_MEM;
          wait_cnt_d = '0;
        end else begin
          ctrl       = run_ctrl;
          lu_stall_d = lu_issue;
        end
      end
      ST_WAIT_MEM: begin
        if (mem_busy) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) state_d = ST_HALT;
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
          ctrl       = run_ctrl;
          lu_stall_d = lu_issue;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      lu_stall_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lu_stall_q <= lu_stall_d;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign idex_write  = ctrl.idex_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign mem_timeout = (state_q == ST_HALT);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_mem_read, ex_reg_write, ex_branch_taken;
  logic       mem_reg_write, wb_reg_write, mem_busy;
  logic       pc_write, ifid_write, idex_write, ifid_flush, idex_flush;
  logic [1:0] fwd_a, fwd_b;
  logic       mem_timeout;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: consecutive busy cycles, halt flag, load-use bubble last cycle.
  int streak   = 0;
  bit halted   = 1'b0;
  bit prev_lu  = 1'b0;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .mem_busy(mem_busy), .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_write(idex_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic bit uses(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

  function automatic bit lu_fire();
    return ex_mem_read && (uses(ex_rd, id_rs1) || uses(ex_rd, id_rs2)) && !prev_lu;
  endfunction

  function automatic bit raw_fire();
`ifdef HAZARD_FWD_EN
    return 1'b0;
`else
    return (ex_reg_write  && (uses(ex_rd, id_rs1)  || uses(ex_rd, id_rs2))) ||
           (mem_reg_write && (uses(mem_rd, id_rs1) || uses(mem_rd, id_rs2)));
`endif
  endfunction

  // Packed as {pc_write, ifid_write, idex_write, ifid_flush, idex_flush}.
  function automatic logic [4:0] exp_ctrl();
    if (halted || mem_busy)     return 5'b00000;
    if (ex_branch_taken)        return 5'b11111;
    if (lu_fire() || raw_fire()) return 5'b00101;
    return 5'b11100;
  endfunction

  function automatic logic [4:0] exp_fwd(input logic [4:0] rs);
`ifdef HAZARD_FWD_EN
    if (mem_reg_write && uses(mem_rd, rs)) return 5'b00010;
    if (wb_reg_write  && uses(wb_rd, rs))  return 5'b00001;
`endif
    return 5'b00000;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".ctrl"}, {pc_write, ifid_write, idex_write, ifid_flush, idex_flush}, exp_ctrl());
    check({tag, ".fwd_a"}, {3'b000, fwd_a}, exp_fwd(ex_rs1));
    check({tag, ".fwd_b"}, {3'b000, fwd_b}, exp_fwd(ex_rs2));
    check({tag, ".timeout"}, {4'b0000, mem_timeout}, {4'b0000, halted});
  endtask

  task automatic update_model();
    bit issued;
    if (!rst) begin
      streak = 0; halted = 1'b0; prev_lu = 1'b0;
    end else begin
      issued  = !halted && !mem_busy && !ex_branch_taken && lu_fire();
      streak  = mem_busy ? streak + 1 : 0;
      if (streak > MEM_TIMEOUT) halted = 1'b1;
      prev_lu = issued;
    end
  endtask

  // Entered just after a rising edge with the cycle's inputs already driven.
  task automatic run_cycle(input string tag);
    #2;
    check_all(tag);
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_mem_read = 0; ex_reg_write = 0; ex_branch_taken = 0;
    mem_reg_write = 0; wb_reg_write = 0; mem_busy = 0;
  endtask

  task automatic async_reset(input string tag);
    #1;
    rst = 1'b0;
    streak = 0; halted = 1'b0; prev_lu = 1'b0;
    #1;
    check_all({tag, ".async"});
    run_cycle({tag, ".held"});
    rst = 1'b1;
  endtask

  task automatic random_cycles(input int n, input int busy_odds);
    for (int i = 0; i < n; i++) begin
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd  = 5'($urandom_range(0, 3));
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      ex_reg_write    = ($urandom_range(0, 1) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_reg_write   = ($urandom_range(0, 1) == 0);
      wb_reg_write    = ($urandom_range(0, 1) == 0);
      mem_busy        = ($urandom_range(0, busy_odds) == 0);
      run_cycle("random");
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_cycle("reset");
    rst = 1'b1;

    // Load-use: one bubble, then the consumer proceeds even though inputs persist.
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5;
    run_cycle("load_use.stall");
    run_cycle("load_use.release");
    clear_inputs();
    run_cycle("load_use.after");

    // Forwarding priority MEM over WB, then WB alone.
    mem_rd = 3; mem_reg_write = 1; wb_rd = 3; wb_reg_write = 1; ex_rs1 = 3; ex_rs2 = 3;
    run_cycle("fwd.mem_wins");
    mem_reg_write = 0;
    run_cycle("fwd.wb");
    clear_inputs();

    // Branch beats a pending load-use.
    ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 4; id_rs2 = 4;
    run_cycle("branch_over_lu");
    clear_inputs();

    // x0 never stalls nor forwards; WB-to-ID match does nothing.
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 0; mem_reg_write = 1; mem_rd = 0;
    wb_reg_write = 1; wb_rd = 0;
    run_cycle("x0");
    clear_inputs();
    wb_reg_write = 1; wb_rd = 9; id_rs1 = 9; id_rs2 = 9;
    run_cycle("wb_to_id");
    clear_inputs();

    // RAW producer in EX, then in MEM.
    ex_reg_write = 1; ex_rd = 7; id_rs2 = 7; ex_rs2 = 7;
    repeat (3) run_cycle("raw.ex");
    ex_reg_write = 0; ex_rd = 0; mem_reg_write = 1; mem_rd = 7;
    run_cycle("raw.mem");
    clear_inputs();
    run_cycle("raw.clear");

    // Short memory wait recovers to normal flow.
    mem_busy = 1;
    repeat (5) run_cycle("busy5.hold");
    mem_busy = 0;
    repeat (2) run_cycle("busy5.resume");

    random_cycles(300, 9);
    clear_inputs();
    run_cycle("random.settle");

    // Long memory wait halts; halt is sticky until reset.
    mem_busy = 1;
    repeat (MEM_TIMEOUT + 4) run_cycle("timeout.busy");
    mem_busy = 0;
    repeat (3) run_cycle("timeout.sticky");
    async_reset("timeout.reset");
    run_cycle("timeout.after_reset");

    // Reset while holding for memory aborts the wait.
    mem_busy = 1;
    repeat (3) run_cycle("stall_reset.busy");
    async_reset("stall_reset");
    mem_busy = 0;
    run_cycle("stall_reset.after");

    random_cycles(300, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
